// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared fetch-stage types and instruction constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'd0,
    FETCH_HALT  = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous FIFO of {pc, instr} with push, pop and flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch stage with buffered delivery, redirect,
//            EBREAK halt and sticky misaligned-redirect fault.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_instr_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  halted_o,
  output logic                  misalign_o
);

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_nxt;
  logic                  w_redir;
  logic                  w_misal;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_head_pc;
  logic [DATA_WIDTH-1:0] w_head_instr;

  // A faulted fetch unit ignores redirects; a redirect voids any handshake.
  assign w_redir = redirect_i && (r_state != FETCH_FAULT);
  assign w_misal = (redirect_pc_i[1:0] != 2'b00);
  assign w_pop   = !w_empty && instr_ready_i && !w_redir;
  assign w_push  = (r_state == FETCH_RUN) && !redirect_i && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH_RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (w_redir) begin
      if (w_misal) begin
        w_state_nxt = FETCH_FAULT;
      end else begin
        w_state_nxt = FETCH_RUN;
        w_pc_nxt    = redirect_pc_i;
      end
    end else if (w_push) begin
      w_pc_nxt = r_pc + DATA_WIDTH'(4);
      if (imem_instr_i == DATA_WIDTH'(EBREAK_INSTR)) w_state_nxt = FETCH_HALT;
    end
  end

  fetch_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_data  ({r_pc, imem_instr_i}),
    .o_data  ({w_head_pc, w_head_instr}),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign imem_addr_o   = r_pc;
  assign instr_valid_o = !w_empty;
  assign instr_o       = w_empty ? DATA_WIDTH'(NOP_INSTR) : w_head_instr;
  assign pc_o          = w_empty ? '0 : w_head_pc;
  assign halted_o      = (r_state == FETCH_HALT) && w_empty;
  assign misalign_o    = (r_state == FETCH_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] FAR_ADDR = 32'hFFFF_FFF0;
  localparam int          M_RUN    = 0;
  localparam int          M_HALT   = 1;
  localparam int          M_FAULT  = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        halted_o;
  logic        misalign_o;

  logic [31:0] ebreak_addr = FAR_ADDR;
  int          n_cmp = 0;
  int          n_fail = 0;

  ent_t        mq[$];
  logic [31:0] mpc;
  int          mmode;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] eb);
    logic [31:0] w;
    if (a == eb) return EBREAK;
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    if (w == EBREAK) w = w ^ 32'h1;
    return w;
  endfunction

  assign imem_instr_i = mem_word(imem_addr_o, ebreak_addr);

  instr_fetch #(
    .DATA_WIDTH (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .halted_o      (halted_o),
    .misalign_o    (misalign_o)
  );

  // One clock: drive inputs, step the reference model at the edge, settle.
  task automatic tick(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
    int   sz;
    bit   popped;
    ent_t e;
    rst = r; instr_ready_i = rdy; redirect_i = rd; redirect_pc_i = rpc;
    @(posedge clk);
    if (r) begin
      mq.delete(); mpc = RST_PC; mmode = M_RUN;
    end else if (rd && mmode != M_FAULT) begin
      mq.delete();
      if (rpc[1:0] != 2'b00) mmode = M_FAULT;
      else begin mmode = M_RUN; mpc = rpc; end
    end else begin
      sz = mq.size();
      popped = (sz > 0) && rdy;
      if (popped) void'(mq.pop_front());
      if (mmode == M_RUN && (sz < DEPTH || popped)) begin
        e.pc = mpc; e.instr = mem_word(mpc, ebreak_addr);
        mq.push_back(e);
        if (e.instr == EBREAK) mmode = M_HALT;
        mpc = mpc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
    n_cmp++; if (imem_addr_o !== RST_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr_o, RST_PC); end
    n_cmp++; if (halted_o !== 1'b0 || misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got halted=%b misalign=%b want 0 0", halted_o, misalign_o); end
    n_cmp++; if (instr_o !== NOP || pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_idle_out: got instr=%h pc=%h want %h 0", instr_o, pc_o, NOP); end
  endtask

  task automatic test_stream;
    logic [31:0] a;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      a = 32'((k - 1) * 4);
      n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== a) begin n_fail++; $display("FAIL stream_pc c%0d: got v=%b pc=%h want 1 %h", k, instr_valid_o, pc_o, a); end
      n_cmp++; if (instr_o !== mem_word(a, ebreak_addr)) begin n_fail++; $display("FAIL stream_instr c%0d: got %h want %h", k, instr_o, mem_word(a, ebreak_addr)); end
    end
  endtask

  task automatic test_stall;
    logic [31:0] a;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (imem_addr_o !== 32'h8) begin n_fail++; $display("FAIL stall_addr: got %h want 8", imem_addr_o); end
    n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0) begin n_fail++; $display("FAIL stall_head: got v=%b pc=%h want 1 0", instr_valid_o, pc_o); end
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      a = 32'(k * 4);
      n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== a) begin n_fail++; $display("FAIL stall_release c%0d: got v=%b pc=%h want 1 %h", k, instr_valid_o, pc_o, a); end
    end
  endtask

  task automatic test_redirect;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'h90);
    n_cmp++; if (instr_valid_o !== 1'b0 || imem_addr_o !== 32'h90) begin n_fail++; $display("FAIL redirect_flush: got v=%b addr=%h want 0 90", instr_valid_o, imem_addr_o); end
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h90 || instr_o !== mem_word(32'h90, ebreak_addr)) begin n_fail++; $display("FAIL redirect_target: got v=%b pc=%h instr=%h want 1 90 %h", instr_valid_o, pc_o, instr_o, mem_word(32'h90, ebreak_addr)); end
  endtask

  task automatic test_ebreak;
    ebreak_addr = 32'hE4;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'hD8);
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (pc_o !== (mq.size() > 0 ? mq[0].pc : 32'h0)) begin n_fail++; $display("FAIL ebreak_seq c%0d: got pc=%h", k, pc_o); end
    end
    n_cmp++; if (imem_addr_o !== 32'hE8) begin n_fail++; $display("FAIL ebreak_addr_hold: got %h want e8", imem_addr_o); end
    n_cmp++; if (halted_o !== 1'b1 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL ebreak_halted: got halted=%b v=%b want 1 0", halted_o, instr_valid_o); end
    tick(1'b0, 1'b1, 1'b1, 32'h50);
    n_cmp++; if (halted_o !== 1'b0) begin n_fail++; $display("FAIL ebreak_resume: got halted=%b want 0", halted_o); end
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h50) begin n_fail++; $display("FAIL ebreak_resume_pc: got v=%b pc=%h want 1 50", instr_valid_o, pc_o); end
    ebreak_addr = FAR_ADDR;
  endtask

  task automatic test_misalign;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'h52);
    n_cmp++; if (misalign_o !== 1'b1 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL misalign_enter: got m=%b v=%b want 1 0", misalign_o, instr_valid_o); end
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b1, (k == 1), 32'h40);
      n_cmp++; if (misalign_o !== 1'b1 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL misalign_sticky c%0d: got m=%b v=%b want 1 0", k, misalign_o, instr_valid_o); end
    end
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %b want 0", misalign_o); end
  endtask

  task automatic test_reset_full;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'h200);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (instr_valid_o !== 1'b0 || imem_addr_o !== RST_PC) begin n_fail++; $display("FAIL rstfull_state: got v=%b addr=%h want 0 %h", instr_valid_o, imem_addr_o, RST_PC); end
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== RST_PC) begin n_fail++; $display("FAIL rstfull_first: got v=%b pc=%h want 1 %h", instr_valid_o, pc_o, RST_PC); end
  endtask

  task automatic test_random;
    logic        r, rdy, rd;
    logic [31:0] rpc, e_instr, e_pc;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 600; k++) begin
      if (k % 100 == 0) ebreak_addr = 32'($urandom_range(31)) << 2;
      r   = ($urandom_range(99) < 2);
      rd  = ($urandom_range(99) < 6);
      rdy = ($urandom_range(99) < 70);
      rpc = 32'($urandom_range(31)) << 2;
      if ($urandom_range(9) == 0) rpc = rpc | 32'($urandom_range(3, 1));
      tick(r, rdy, rd, rpc);
      e_instr = (mq.size() > 0) ? mq[0].instr : NOP;
      e_pc    = (mq.size() > 0) ? mq[0].pc : 32'h0;
      n_cmp++; if (instr_valid_o !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", k, instr_valid_o, mq.size() > 0); end
      n_cmp++; if (instr_o !== e_instr || pc_o !== e_pc) begin n_fail++; $display("FAIL rnd_head c%0d: got %h@%h want %h@%h", k, instr_o, pc_o, e_instr, e_pc); end
      n_cmp++; if (halted_o !== (mmode == M_HALT && mq.size() == 0)) begin n_fail++; $display("FAIL rnd_halted c%0d: got %b", k, halted_o); end
      n_cmp++; if (misalign_o !== (mmode == M_FAULT)) begin n_fail++; $display("FAIL rnd_misalign c%0d: got %b", k, misalign_o); end
      if (mmode != M_FAULT) begin
        n_cmp++; if (imem_addr_o !== mpc) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", k, imem_addr_o, mpc); end
      end
    end
    ebreak_addr = FAR_ADDR;
  endtask

  initial begin
    rst = 1'b1; instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    mpc = RST_PC; mmode = M_RUN;
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_ebreak;
    test_misalign;
    test_reset_full;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, address and instruction width.
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_0000, first fetch byte address.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 2, fetch buffer entries (power of two, >=2).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset; one clock, synchronous and active-high.
REQ-006 imem_addr_o  output  DATA_WIDTH  byte address driven to instruction memory.
REQ-007 imem_instr_i  input  DATA_WIDTH  instruction returned combinationally, same cycle as imem_addr_o.
REQ-008 redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-009 redirect_pc_i  input  DATA_WIDTH  redirect byte target.
REQ-010 instr_valid_o  output  1  head entry valid to decode.
REQ-011 instr_ready_i  input  1  decode accepts head entry.
REQ-012 instr_o  output  DATA_WIDTH  head instruction.
REQ-013 pc_o  output  DATA_WIDTH  head instruction byte address.
REQ-014 halted_o  output  1  EBREAK delivered, fetching stopped.
REQ-015 misalign_o  output  1  sticky misaligned-redirect fault.

Function
REQ-016 imem_addr_o SHALL equal the fetch PC register at all times.
REQ-017 Push ({pc, instr} into FIFO) SHALL occur when state=RUN, no redirect_i, and FIFO not full or a pop occurs the same cycle.
REQ-018 On push, fetch PC SHALL advance by 4, wrapping modulo 2^DATA_WIDTH; otherwise fetch PC SHALL hold.
REQ-019 Pop SHALL occur when instr_valid_o and instr_ready_i are both 1; instr_valid_o SHALL equal FIFO not-empty.
REQ-020 When instr_valid_o=0, instr_o SHALL be 32'h0000_0013 and pc_o SHALL be 0.
REQ-021 Latency: instruction at address A fetched in cycle n SHALL be presented at earliest in cycle n+1; sustained throughput one instruction per cycle with instr_ready_i=1.
REQ-022 redirect_i SHALL have priority over push and pop: FIFO flushed (including head; a same-cycle handshake is void), fetch PC <= redirect_pc_i, instr_valid_o=0 in the following cycle.
REQ-023 States: RUN, HALT, FAULT. RUN->HALT when the pushed instruction equals 32'h0010_0073 (EBREAK); no further pushes in HALT.
REQ-024 HALT->RUN on aligned redirect_i (speculative EBREAK cancelled); halted_o SHALL be 1 only in HALT with FIFO empty.
REQ-025 Redirect with redirect_pc_i[1:0]!=0 from any state SHALL flush, enter FAULT, set misalign_o=1; FAULT exits only by reset, no fetches, redirects ignored.
REQ-026 FIFO full with simultaneous pop and fetch SHALL push and pop in the same cycle with no loss or duplication.

Reset
REQ-027 While rst=1 at a clock edge: fetch PC <= RESET_PC, FIFO empty, state RUN, misalign_o=0, halted_o=0, instr_valid_o=0.
REQ-028 Reset mid-operation SHALL discard all buffered entries; first post-reset fetch SHALL be at RESET_PC in the cycle after rst deasserts.

Structure
REQ-029 Shared package fetch_pkg SHALL hold fetch_state_e {FETCH_RUN, FETCH_HALT, FETCH_FAULT}, EBREAK_INSTR=32'h0010_0073, NOP_INSTR=32'h0000_0013.
REQ-030 Buffer SHALL be one sub-module fetch_fifo: synchronous FIFO of {pc, instr}, push/pop/flush, full/empty flags.

Verification
REQ-031 Reset, instr_ready_i=1 always -> pc_o 0x0,0x4,0x8,... on consecutive cycles starting cycle 1, instr_o matches memory.
REQ-032 instr_ready_i=0 for 5 cycles after reset -> 2 entries held, imem_addr_o holds 0x8; on release pc_o 0x0,0x4,0x8 delivered once each.
REQ-033 FIFO full, redirect_i with redirect_pc_i=0x90 -> next cycle instr_valid_o=0, then pc_o=0x90; flushed entries never presented.
REQ-034 EBREAK at 0xE4 -> imem_addr_o holds 0xE8, after EBREAK popped halted_o=1; redirect to 0x50 -> halted_o=0, pc_o=0x50 presented.
REQ-035 Redirect to 0x52 -> misalign_o=1, instr_valid_o=0 until rst; later redirect to 0x40 ignored.
REQ-036 rst asserted with FIFO full -> next cycle instr_valid_o=0, imem_addr_o=RESET_PC.
